// File: rtl/strip_header_pkg.sv
// rtl/strip_header_pkg.sv - shared header layout, states and helpers for the header strip/insert pair
package strip_header_pkg;

    typedef enum logic [1:0] {
        HEADER  = 2'd0,
        PAYLOAD = 2'd1,
        DROP    = 2'd2
    } state_e;

    // Header beat layout: [31:0] magic, [63:32] payload size in bytes.
    localparam int MAGIC_LSB = 0;
    localparam int SIZE_LSB  = 32;
    localparam int FIELD_W   = 32;

    localparam logic [FIELD_W-1:0] DEFAULT_MAGIC = 32'hA5A5_5A5A;

    // Widest TKEEP the popcount helper accepts; narrower keeps are zero-extended.
    localparam int KEEP_MAX = 128;

    function automatic logic [31:0] popcount(input logic [KEEP_MAX-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - 2-entry skid buffer with registered outputs and registered ready
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_tdata_i/tkeep_i/tlast_i  beat to store
//   s_push_i                   store the beat (caller only pushes while s_tready_o is high)
//   s_tready_o                 registered "buffer not full"
//   m_tdata_o/tkeep_o/tlast_o  output beat, held stable while m_tvalid_o && !m_tready_i
//   m_tvalid_o, m_tready_i     output handshake
module axis_skid_buffer #(
    parameter int DW = 512
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   s_tdata_i,
    input  logic [DW/8-1:0] s_tkeep_i,
    input  logic            s_tlast_i,
    input  logic            s_push_i,
    output logic            s_tready_o,
    output logic [DW-1:0]   m_tdata_o,
    output logic [DW/8-1:0] m_tkeep_o,
    output logic            m_tlast_o,
    output logic            m_tvalid_o,
    input  logic            m_tready_i
);
    localparam int EW = DW + DW/8 + 1;

    logic [EW-1:0] out_q, out_d, skid_q, skid_d, in_entry;
    logic          out_valid_q, out_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          ready_q;
    logic          pop;

    assign in_entry = {s_tlast_i, s_tkeep_i, s_tdata_i};
    assign pop      = out_valid_q && m_tready_i;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || pop) begin
            // Output slot frees up: refill from skid first, then from the input.
            // A full skid means ready was low, so no push can coincide with it.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (s_push_i) begin
                out_d       = in_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (s_push_i) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= !skid_valid_d;
        end
    end

    assign s_tready_o = ready_q;
    assign m_tvalid_o = out_valid_q;
    assign {m_tlast_o, m_tkeep_o, m_tdata_o} = out_q;

endmodule

// File: rtl/strip_header.sv
// rtl/strip_header.sv - validates and strips the header beat of AXI-Stream frames
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   AXIS_IN_*            ingress frame stream (first beat is the header)
//   AXIS_OUT_*           payload-only stream
//   FRAME_SIZE           size field of the last good header
//   HDR_ERR              one-cycle pulse on a bad-magic header
//   LEN_ERR              one-cycle pulse when payload byte count != FRAME_SIZE at TLAST
module strip_header
    import strip_header_pkg::*;
#(
    parameter int          DW    = 512,
    parameter logic [31:0] MAGIC = DEFAULT_MAGIC
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [DW-1:0]   AXIS_IN_TDATA,
    input  logic            AXIS_IN_TVALID,
    input  logic [DW/8-1:0] AXIS_IN_TKEEP,
    input  logic            AXIS_IN_TLAST,
    output logic            AXIS_IN_TREADY,
    output logic [DW-1:0]   AXIS_OUT_TDATA,
    output logic            AXIS_OUT_TVALID,
    input  logic            AXIS_OUT_TREADY,
    output logic [DW/8-1:0] AXIS_OUT_TKEEP,
    output logic            AXIS_OUT_TLAST,
    output logic [31:0]     FRAME_SIZE,
    output logic            HDR_ERR,
    output logic            LEN_ERR
);
    state_e        state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   size_q, size_d;
    logic          hdr_err_q, hdr_err_d;
    logic          len_err_q, len_err_d;
    logic          push;
    logic          in_ready;
    logic          hs;
    logic          magic_ok;
    logic [31:0]   hdr_size;
    logic [KEEP_MAX-1:0] keep_ext;
    logic [31:0]   byte_sum;

    assign hs       = AXIS_IN_TVALID && in_ready;
    assign magic_ok = AXIS_IN_TDATA[MAGIC_LSB +: FIELD_W] == MAGIC;
    assign hdr_size = AXIS_IN_TDATA[SIZE_LSB +: FIELD_W];
    assign keep_ext = KEEP_MAX'(AXIS_IN_TKEEP);
    // Running total including the current beat; wraps modulo 2^32.
    assign byte_sum = cnt_q + popcount(keep_ext);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        size_d    = size_q;
        hdr_err_d = 1'b0;
        len_err_d = 1'b0;
        push      = 1'b0;
        if (hs) begin
            case (state_q)
                HEADER: begin
                    if (magic_ok) begin
                        size_d = hdr_size;
                        cnt_d  = '0;
                        if (AXIS_IN_TLAST) begin
                            // Header-only frame: zero payload bytes arrived.
                            len_err_d = (hdr_size != 32'd0);
                        end else begin
                            state_d = PAYLOAD;
                        end
                    end else begin
                        hdr_err_d = 1'b1;
                        if (!AXIS_IN_TLAST) state_d = DROP;
                    end
                end
                PAYLOAD: begin
                    push  = 1'b1;
                    cnt_d = byte_sum;
                    if (AXIS_IN_TLAST) begin
                        len_err_d = (byte_sum != size_q);
                        state_d   = HEADER;
                    end
                end
                DROP: begin
                    if (AXIS_IN_TLAST) state_d = HEADER;
                end
                default: state_d = HEADER;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= HEADER;
            cnt_q     <= '0;
            size_q    <= '0;
            hdr_err_q <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            size_q    <= size_d;
            hdr_err_q <= hdr_err_d;
            len_err_q <= len_err_d;
        end
    end

    axis_skid_buffer #(.DW(DW)) u_skid (
        .clk        (clk),
        .rst_n      (resetn),
        .s_tdata_i  (AXIS_IN_TDATA),
        .s_tkeep_i  (AXIS_IN_TKEEP),
        .s_tlast_i  (AXIS_IN_TLAST),
        .s_push_i   (push),
        .s_tready_o (in_ready),
        .m_tdata_o  (AXIS_OUT_TDATA),
        .m_tkeep_o  (AXIS_OUT_TKEEP),
        .m_tlast_o  (AXIS_OUT_TLAST),
        .m_tvalid_o (AXIS_OUT_TVALID),
        .m_tready_i (AXIS_OUT_TREADY)
    );

    assign AXIS_IN_TREADY = in_ready;
    assign FRAME_SIZE     = size_q;
    assign HDR_ERR        = hdr_err_q;
    assign LEN_ERR        = len_err_q;

endmodule

// File: tb/tb_strip_header.sv
// tb/tb_strip_header.sv - scoreboard bench for strip_header
module tb_strip_header;
    import strip_header_pkg::*;

    localparam int DW = 512;
    localparam int KW = DW/8;
    localparam logic [31:0] M = 32'hA5A5_5A5A;

    logic          clk = 1'b0;
    logic          resetn;
    logic [DW-1:0] AXIS_IN_TDATA;
    logic          AXIS_IN_TVALID;
    logic [KW-1:0] AXIS_IN_TKEEP;
    logic          AXIS_IN_TLAST;
    logic          AXIS_IN_TREADY;
    logic [DW-1:0] AXIS_OUT_TDATA;
    logic          AXIS_OUT_TVALID;
    logic          AXIS_OUT_TREADY;
    logic [KW-1:0] AXIS_OUT_TKEEP;
    logic          AXIS_OUT_TLAST;
    logic [31:0]   FRAME_SIZE;
    logic          HDR_ERR;
    logic          LEN_ERR;

    always #5 clk = ~clk;

    strip_header #(.DW(DW), .MAGIC(M)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .AXIS_IN_TDATA   (AXIS_IN_TDATA),
        .AXIS_IN_TVALID  (AXIS_IN_TVALID),
        .AXIS_IN_TKEEP   (AXIS_IN_TKEEP),
        .AXIS_IN_TLAST   (AXIS_IN_TLAST),
        .AXIS_IN_TREADY  (AXIS_IN_TREADY),
        .AXIS_OUT_TDATA  (AXIS_OUT_TDATA),
        .AXIS_OUT_TVALID (AXIS_OUT_TVALID),
        .AXIS_OUT_TREADY (AXIS_OUT_TREADY),
        .AXIS_OUT_TKEEP  (AXIS_OUT_TKEEP),
        .AXIS_OUT_TLAST  (AXIS_OUT_TLAST),
        .FRAME_SIZE      (FRAME_SIZE),
        .HDR_ERR         (HDR_ERR),
        .LEN_ERR         (LEN_ERR)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    beat_t sb[$];
    beat_t exp_beat;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    pushed = 0, popped = 0, out_beats = 0, hdr_cnt = 0, len_cnt = 0;
    bit    chk_ready = 0;
    bit    prev_stall = 0;
    int    ready_mode = 0;   // 0: sink always ready, 1: random, 2: never ready

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sink ready driver
    initial begin
        AXIS_OUT_TREADY = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       AXIS_OUT_TREADY = 1'b1;
                1:       AXIS_OUT_TREADY = 1'($urandom_range(0, 1));
                default: AXIS_OUT_TREADY = 1'b0;
            endcase
        end
    end

    // Output monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (chk_ready)
                    check("in_tready_vs_occupancy", DW'(AXIS_IN_TREADY), DW'((pushed - popped) < 2));
                if (prev_stall)
                    check("out_valid_hold", DW'(AXIS_OUT_TVALID), DW'(1));
                prev_stall = AXIS_OUT_TVALID && !AXIS_OUT_TREADY;
                if (HDR_ERR) hdr_cnt++;
                if (LEN_ERR) len_cnt++;
                if (HDR_ERR || LEN_ERR)
                    check("err_exclusive", DW'(HDR_ERR && LEN_ERR), DW'(0));
                if (AXIS_OUT_TVALID && AXIS_OUT_TREADY) begin
                    check("sb_nonempty", DW'(sb.size() != 0), DW'(1));
                    if (sb.size() != 0) begin
                        exp_beat = sb.pop_front();
                        check("out_tdata", AXIS_OUT_TDATA, exp_beat.data);
                        check("out_tkeep", DW'(AXIS_OUT_TKEEP), DW'(exp_beat.keep));
                        check("out_tlast", DW'(AXIS_OUT_TLAST), DW'(exp_beat.last));
                    end
                    popped++;
                    out_beats++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [DW-1:0] make_hdr(input logic [31:0] magic, input logic [31:0] size);
        logic [DW-1:0] r;
        r = rand_data();
        r[31:0]  = magic;
        r[63:32] = size;
        return r;
    endfunction

    function automatic logic [KW-1:0] keep_n(input int n);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < n; i++) k[i] = 1'b1;
        return k;
    endfunction

    // Enter just after a rising edge; returns #1 after the accepting edge with valid still high.
    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input bit payload);
        int w;
        w = 0;
        AXIS_IN_TDATA  = d;
        AXIS_IN_TKEEP  = k;
        AXIS_IN_TLAST  = l;
        AXIS_IN_TVALID = 1'b1;
        @(negedge clk);
        while (!AXIS_IN_TREADY && w < 200) begin
            w++;
            @(negedge clk);
        end
        if (!AXIS_IN_TREADY) begin
            check("in_accept_timeout", DW'(AXIS_IN_TREADY), DW'(1));
            AXIS_IN_TVALID = 1'b0;
            return;
        end
        @(posedge clk);
        if (payload) begin
            sb.push_back('{data: d, keep: k, last: l});
            pushed++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        AXIS_IN_TVALID = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        AXIS_IN_TVALID = 1'b0;
        while ((sb.size() != 0 || AXIS_OUT_TVALID) && w < 500) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain_sb_empty", DW'(sb.size()), DW'(0));
    endtask

    int base_out, base_hdr, base_len;
    int n_tail;
    logic [31:0] sz;
    logic [KW-1:0] k36;

    task automatic mark();
        base_out = out_beats;
        base_hdr = hdr_cnt;
        base_len = len_cnt;
    endtask

    initial begin
        resetn         = 1'b0;
        AXIS_IN_TDATA  = '0;
        AXIS_IN_TVALID = 1'b0;
        AXIS_IN_TKEEP  = '0;
        AXIS_IN_TLAST  = 1'b0;
        k36            = 64'h0000000F_FFFFFFFF;
        #12;
        check("rst_out_tvalid", DW'(AXIS_OUT_TVALID), DW'(0));
        check("rst_out_tdata", AXIS_OUT_TDATA, DW'(0));
        check("rst_out_tkeep", DW'(AXIS_OUT_TKEEP), DW'(0));
        check("rst_out_tlast", DW'(AXIS_OUT_TLAST), DW'(0));
        check("rst_in_tready", DW'(AXIS_IN_TREADY), DW'(0));
        check("rst_frame_size", DW'(FRAME_SIZE), DW'(0));
        check("rst_errs", DW'({HDR_ERR, LEN_ERR}), DW'(0));
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1; chk_ready = 1;

        // Good frame
        mark();
        send_beat(make_hdr(M, 192), '1, 1'b0, 1'b0);
        check("t1_no_valid_after_header", DW'(AXIS_OUT_TVALID), DW'(0));
        send_beat(rand_data(), '1, 1'b0, 1'b1);
        check("t1_first_valid_latency", DW'(AXIS_OUT_TVALID), DW'(1));
        send_beat(rand_data(), '1, 1'b0, 1'b1);
        send_beat(rand_data(), '1, 1'b1, 1'b1);
        drain();
        check("t1_out_beats", DW'(out_beats - base_out), DW'(3));
        check("t1_frame_size", DW'(FRAME_SIZE), DW'(192));
        check("t1_no_hdr_err", DW'(hdr_cnt - base_hdr), DW'(0));
        check("t1_no_len_err", DW'(len_cnt - base_len), DW'(0));

        // Partial tail, matching size
        mark();
        send_beat(make_hdr(M, 100), '1, 1'b0, 1'b0);
        send_beat(rand_data(), '1, 1'b0, 1'b1);
        send_beat(rand_data(), k36, 1'b1, 1'b1);
        check("t2_len_err_low", DW'(LEN_ERR), DW'(0));
        drain();
        check("t2_out_beats", DW'(out_beats - base_out), DW'(2));
        check("t2_len_cnt", DW'(len_cnt - base_len), DW'(0));

        // Partial tail, size off by one
        mark();
        send_beat(make_hdr(M, 99), '1, 1'b0, 1'b0);
        send_beat(rand_data(), '1, 1'b0, 1'b1);
        send_beat(rand_data(), k36, 1'b1, 1'b1);
        check("t2b_len_err_timing", DW'(LEN_ERR), DW'(1));
        drain();
        check("t2b_out_beats", DW'(out_beats - base_out), DW'(2));
        check("t2b_len_cnt", DW'(len_cnt - base_len), DW'(1));
        check("t2b_frame_size", DW'(FRAME_SIZE), DW'(99));

        // Bad magic, dropped frame, then a good frame
        mark();
        send_beat(make_hdr(32'h0, 500), '1, 1'b0, 1'b0);
        check("t3_hdr_err_timing", DW'(HDR_ERR), DW'(1));
        for (int i = 0; i < 4; i++) send_beat(rand_data(), '1, 1'(i == 3), 1'b0);
        drain();
        check("t3_out_beats", DW'(out_beats - base_out), DW'(0));
        check("t3_hdr_cnt", DW'(hdr_cnt - base_hdr), DW'(1));
        check("t3_frame_size_kept", DW'(FRAME_SIZE), DW'(99));
        mark();
        send_beat(make_hdr(M, 64), '1, 1'b0, 1'b0);
        send_beat(rand_data(), '1, 1'b1, 1'b1);
        drain();
        check("t3b_out_beats", DW'(out_beats - base_out), DW'(1));
        check("t3b_frame_size", DW'(FRAME_SIZE), DW'(64));
        check("t3b_no_errs", DW'((hdr_cnt - base_hdr) + (len_cnt - base_len)), DW'(0));

        // Random backpressure, back-to-back frames
        mark();
        ready_mode = 1;
        sz = '0;
        for (int f = 0; f < 20; f++) begin
            n_tail = $urandom_range(1, 64);
            sz = 32'(3*64 + n_tail);
            send_beat(make_hdr(M, sz), '1, 1'b0, 1'b0);
            for (int b = 0; b < 4; b++)
                send_beat(rand_data(), (b == 3) ? keep_n(n_tail) : '1, 1'(b == 3), 1'b1);
        end
        drain();
        ready_mode = 0;
        check("t4_out_beats", DW'(out_beats - base_out), DW'(80));
        check("t4_no_len_err", DW'(len_cnt - base_len), DW'(0));
        check("t4_no_hdr_err", DW'(hdr_cnt - base_hdr), DW'(0));
        check("t4_frame_size", DW'(FRAME_SIZE), DW'(sz));

        // Header-only frames
        mark();
        send_beat(make_hdr(M, 0), '1, 1'b1, 1'b0);
        check("t5_len_err_low", DW'(LEN_ERR), DW'(0));
        idle(3);
        check("t5_frame_size0", DW'(FRAME_SIZE), DW'(0));
        check("t5_out_beats", DW'(out_beats - base_out), DW'(0));
        check("t5_no_errs", DW'((hdr_cnt - base_hdr) + (len_cnt - base_len)), DW'(0));
        send_beat(make_hdr(M, 64), '1, 1'b1, 1'b0);
        check("t5b_len_err_timing", DW'(LEN_ERR), DW'(1));
        idle(3);
        check("t5b_len_cnt", DW'(len_cnt - base_len), DW'(1));
        check("t5b_frame_size", DW'(FRAME_SIZE), DW'(64));
        check("t5b_out_beats", DW'(out_beats - base_out), DW'(0));

        // Reset in the middle of a payload
        ready_mode = 2;
        idle(2);
        send_beat(make_hdr(M, 320), '1, 1'b0, 1'b0);
        send_beat(rand_data(), '1, 1'b0, 1'b1);
        send_beat(rand_data(), '1, 1'b0, 1'b1);
        chk_ready = 0;
        resetn = 1'b0;
        AXIS_IN_TVALID = 1'b0;
        #1;
        check("t6_rst_out_tvalid", DW'(AXIS_OUT_TVALID), DW'(0));
        check("t6_rst_out_tdata", AXIS_OUT_TDATA, DW'(0));
        check("t6_rst_out_tkeep", DW'(AXIS_OUT_TKEEP), DW'(0));
        check("t6_rst_out_tlast", DW'(AXIS_OUT_TLAST), DW'(0));
        check("t6_rst_in_tready", DW'(AXIS_IN_TREADY), DW'(0));
        check("t6_rst_frame_size", DW'(FRAME_SIZE), DW'(0));
        sb.delete();
        pushed = 0;
        popped = 0;
        prev_stall = 0;
        ready_mode = 0;
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1; chk_ready = 1;
        mark();
        send_beat(make_hdr(M, 64), '1, 1'b0, 1'b0);
        send_beat(rand_data(), '1, 1'b1, 1'b1);
        drain();
        check("t6_out_beats", DW'(out_beats - base_out), DW'(1));
        check("t6_frame_size", DW'(FRAME_SIZE), DW'(64));
        check("t6_no_errs", DW'((hdr_cnt - base_hdr) + (len_cnt - base_len)), DW'(0));

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
